// File: rtl/audio_pkg.sv
// audio_pkg: shared constants for the tone sequencer.
// Note table, DAC midscale, FSM states and counter widths.
package audio_pkg;

  localparam int HALF_W = 17;
  localparam int DUR_W  = 9;
  localparam int TICK_W = 16;

  localparam logic [7:0] DAC_MID = 8'd128;

  localparam logic [HALF_W-1:0] NOTE_HALF [0:2] =
    '{17'd25000, 17'd16667, 17'd12500};
  localparam logic [DUR_W-1:0] NOTE_DUR [0:2] =
    '{9'd200, 9'd200, 9'd400};

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP,
    S_DONE
  } seq_state_e;

  function automatic logic [HALF_W-1:0] note_half(
    input logic [1:0] i
  );
    case (i)
      2'd0:    note_half = NOTE_HALF[0];
      2'd1:    note_half = NOTE_HALF[1];
      default: note_half = NOTE_HALF[2];
    endcase
  endfunction

  function automatic logic [DUR_W-1:0] note_dur(
    input logic [1:0] i
  );
    case (i)
      2'd0:    note_dur = NOTE_DUR[0];
      2'd1:    note_dur = NOTE_DUR[1];
      default: note_dur = NOTE_DUR[2];
    endcase
  endfunction

endpackage

// File: rtl/square_tone.sv
// square_tone: half-period divider and phase flop.
// Ports: clock, clear (phase=HI, count=0), half_period, amplitude, sample.
module square_tone
  import audio_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic [HALF_W-1:0] half_period,
  input  logic [7:0]        amplitude,
  output logic [7:0]        sample
);

  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (clear) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == half_period - 1'b1) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clock) begin
    cnt_q   <= cnt_d;
    phase_q <= phase_d;
  end

  assign sample = phase_q ? DAC_MID + amplitude
                          : DAC_MID - amplitude;

endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: plays a fixed three-note jingle as DAC samples.
// In: CLOCK_50, reset, start, stop. Out: busy, done, note_idx, AUDIO_OUT.
module tone_sequencer
  import audio_pkg::*;
#(
  parameter int TICK_CYCLES = 50000,
  parameter int GAP_TICKS   = 50,
  parameter int AMPLITUDE   = 127
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  output logic       busy,
  output logic       done,
  output logic [1:0] note_idx,
  output logic [7:0] AUDIO_OUT
);

  seq_state_e        state_q, state_d;
  logic              start_q, stop_q;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [1:0]        idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick_end;
  logic [DUR_W-1:0]  dur_inc;
  logic              tone_clr;
  logic [7:0]        tone_sample;

  // start/stop are registered first, so the FSM acts one edge later
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    dur_d    = dur_q;
    idx_d    = idx_q;
    tick_end = tick_q == TICK_W'(TICK_CYCLES - 1);
    dur_inc  = dur_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (start_q && !stop_q) begin
          state_d = S_PLAY;
          idx_d   = 2'd0;
          tick_d  = '0;
          dur_d   = '0;
        end
      end
      S_PLAY: begin
        tick_d = tick_end ? '0 : tick_q + 1'b1;
        if (tick_end) begin
          dur_d = dur_inc;
          if (dur_inc == note_dur(idx_q)) begin
            dur_d   = '0;
            state_d = (idx_q == 2'd2) ? S_DONE : S_GAP;
          end
        end
      end
      S_GAP: begin
        tick_d = tick_end ? '0 : tick_q + 1'b1;
        if (tick_end) begin
          dur_d = dur_inc;
          if (dur_inc == DUR_W'(GAP_TICKS)) begin
            dur_d   = '0;
            state_d = S_PLAY;
            idx_d   = idx_q + 2'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (stop_q && state_q != S_IDLE) begin
      state_d = S_IDLE;
      tick_d  = '0;
      dur_d   = '0;
    end
    busy_d   = state_d == S_PLAY || state_d == S_GAP;
    done_d   = state_d == S_DONE;
    // tone restarts at HI on every entry into PLAY
    tone_clr = state_q != S_PLAY || state_d != S_PLAY;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      tick_q  <= '0;
      dur_q   <= '0;
      idx_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      stop_q  <= stop;
      tick_q  <= tick_d;
      dur_q   <= dur_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  square_tone u_tone (
    .clock       (CLOCK_50),
    .clear       (reset | tone_clr),
    .half_period (note_half(idx_q)),
    .amplitude   (8'(AMPLITUDE)),
    .sample      (tone_sample)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign note_idx  = idx_q;
  assign AUDIO_OUT = (state_q == S_PLAY) ? tone_sample : DAC_MID;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: scoreboard bench for tone_sequencer.
// Three instances: main (T=8), AMPLITUDE=0 twin, long-tick tone check.
module tb_tone_sequencer;

  localparam int RUN = 6433;

  typedef struct {
    int         cyc;
    logic [7:0] audio;
    logic       busy;
    logic       done;
    logic [1:0] idx;
  } snap_t;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic reset, start, stop;
  logic rst_t, start_t, stop_t;

  logic [7:0] aud [3];
  logic       bsy [3];
  logic       dn  [3];
  logic [1:0] ix  [3];

  snap_t sq [3][$];
  int    dq [3][$];
  string nm [3] = '{"main", "amp0", "tone"};

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int z_off = 0;

  always @(posedge clk) cyc <= cyc + 1;

  tone_sequencer #(.TICK_CYCLES(8), .GAP_TICKS(2),
                   .AMPLITUDE(127)) u_main (
    .CLOCK_50(clk), .reset(reset), .start(start), .stop(stop),
    .busy(bsy[0]), .done(dn[0]), .note_idx(ix[0]),
    .AUDIO_OUT(aud[0]));

  tone_sequencer #(.TICK_CYCLES(8), .GAP_TICKS(2),
                   .AMPLITUDE(0)) u_amp0 (
    .CLOCK_50(clk), .reset(reset), .start(start), .stop(stop),
    .busy(bsy[1]), .done(dn[1]), .note_idx(ix[1]),
    .AUDIO_OUT(aud[1]));

  tone_sequencer #(.TICK_CYCLES(130), .GAP_TICKS(2),
                   .AMPLITUDE(127)) u_tone (
    .CLOCK_50(clk), .reset(rst_t), .start(start_t), .stop(stop_t),
    .busy(bsy[2]), .done(dn[2]), .note_idx(ix[2]),
    .AUDIO_OUT(aud[2]));

  always @(negedge clk) begin : mon
    snap_t e;
    int    de;
    for (int u = 0; u < 3; u++) begin
      while (sq[u].size() != 0 && sq[u][0].cyc < cyc) begin
        e = sq[u].pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL %s snap missed @%0d", nm[u], e.cyc);
      end
      if (sq[u].size() != 0 && sq[u][0].cyc == cyc) begin
        e = sq[u].pop_front();
        n_cmp++;
        if ({aud[u], bsy[u], dn[u], ix[u]} !==
            {e.audio, e.busy, e.done, e.idx}) begin
          n_bad++;
          $display("FAIL %s snap @%0d: got a=%0d b=%0b d=%0b i=%0d want a=%0d b=%0b d=%0b i=%0d",
                   nm[u], cyc, aud[u], bsy[u], dn[u], ix[u],
                   e.audio, e.busy, e.done, e.idx);
        end
      end
      if (dn[u] === 1'b1) begin
        n_cmp++;
        if (dq[u].size() == 0) begin
          n_bad++;
          $display("FAIL %s done unexpected @%0d, want none",
                   nm[u], cyc);
        end else begin
          de = dq[u].pop_front();
          if (de != cyc) begin
            n_bad++;
            $display("FAIL %s done time got %0d want %0d",
                     nm[u], cyc, de);
          end
        end
      end
    end
    if (reset === 1'b0 && aud[1] !== 8'd128) z_off++;
  end

  task automatic exp_m(int c, logic [7:0] a, logic b,
                       logic d, logic [1:0] i);
    snap_t s;
    s = '{c, a, b, d, i};
    sq[0].push_back(s);
    s.audio = 8'd128;
    sq[1].push_back(s);
  endtask

  task automatic exp_t(int c, logic [7:0] a, logic b,
                       logic [1:0] i);
    snap_t s;
    s = '{c, a, b, 1'b0, i};
    sq[2].push_back(s);
  endtask

  task automatic exp_done(int c);
    dq[0].push_back(c);
    dq[1].push_back(c);
  endtask

  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic main_seq();
    int k;
    int m;
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    exp_m(cyc + 1, 8'd128, 0, 0, 2'd0);
    exp_m(cyc + 3, 8'd128, 0, 0, 2'd0);
    wait_to(cyc + 4);

    // full uninterrupted run
    k = cyc + 1;
    exp_m(k,        8'd128, 0, 0, 2'd0);
    exp_m(k + 1,    8'd255, 1, 0, 2'd0);
    exp_m(k + 1600, 8'd255, 1, 0, 2'd0);
    exp_m(k + 1601, 8'd128, 1, 0, 2'd0);
    exp_m(k + 1617, 8'd255, 1, 0, 2'd1);
    exp_m(k + 3216, 8'd255, 1, 0, 2'd1);
    exp_m(k + 3217, 8'd128, 1, 0, 2'd1);
    exp_m(k + 3233, 8'd255, 1, 0, 2'd2);
    exp_m(k + 6432, 8'd255, 1, 0, 2'd2);
    exp_m(k + RUN,  8'd128, 0, 1, 2'd2);
    exp_m(k + RUN + 1, 8'd128, 0, 0, 2'd2);
    exp_done(k + RUN);
    pulse_start();
    wait_to(k + RUN + 6);

    // stop during note 1
    k = cyc + 1;
    m = k + 2000;
    exp_m(k + 1617, 8'd255, 1, 0, 2'd1);
    exp_m(m,        8'd255, 1, 0, 2'd1);
    exp_m(m + 1,    8'd128, 0, 0, 2'd1);
    exp_m(m + 10,   8'd128, 0, 0, 2'd1);
    pulse_start();
    wait_to(m - 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_to(m + 12);

    // replay, with start re-pulsed in GAP and in note 2
    k = cyc + 1;
    exp_m(k + 1,    8'd255, 1, 0, 2'd0);
    exp_m(k + 1606, 8'd128, 1, 0, 2'd0);
    exp_m(k + 1617, 8'd255, 1, 0, 2'd1);
    exp_m(k + 4002, 8'd255, 1, 0, 2'd2);
    exp_m(k + RUN,  8'd128, 0, 1, 2'd2);
    exp_done(k + RUN);
    pulse_start();
    wait_to(k + 1604);
    pulse_start();
    wait_to(k + 3999);
    pulse_start();
    wait_to(k + RUN + 6);

    // start and stop together in IDLE
    k = cyc + 1;
    exp_m(k + 1, 8'd128, 0, 0, 2'd2);
    exp_m(k + 2, 8'd128, 0, 0, 2'd2);
    exp_m(k + 5, 8'd128, 0, 0, 2'd2);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    wait_to(k + 6);

    // reset during PLAY
    k = cyc + 1;
    m = k + 100;
    exp_m(k + 1,  8'd255, 1, 0, 2'd0);
    exp_m(k + 50, 8'd255, 1, 0, 2'd0);
    exp_m(m,      8'd128, 0, 0, 2'd0);
    exp_m(m + 3,  8'd128, 0, 0, 2'd0);
    pulse_start();
    wait_to(m - 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_to(m + 5);
  endtask

  task automatic tone_seq();
    int k;
    rst_t   = 1'b1;
    start_t = 1'b0;
    stop_t  = 1'b0;
    repeat (3) @(negedge clk);
    rst_t = 1'b0;
    @(negedge clk);
    k = cyc + 1;
    exp_t(k + 1,     8'd255, 1, 2'd0);
    exp_t(k + 25000, 8'd255, 1, 2'd0);
    exp_t(k + 25001, 8'd1,   1, 2'd0);
    exp_t(k + 26000, 8'd1,   1, 2'd0);
    exp_t(k + 26001, 8'd128, 1, 2'd0);
    exp_t(k + 26260, 8'd128, 1, 2'd0);
    exp_t(k + 26261, 8'd255, 1, 2'd1);
    exp_t(k + 26300, 8'd255, 1, 2'd1);
    exp_t(k + 26301, 8'd128, 0, 2'd1);
    start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    wait_to(k + 26299);
    stop_t = 1'b1;
    @(negedge clk);
    stop_t = 1'b0;
    wait_to(k + 26305);
  endtask

  initial begin
    fork
      main_seq();
      tone_seq();
    join
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      n_cmp++;
      if (sq[u].size() + dq[u].size() != 0) begin
        n_bad++;
        $display("FAIL %s pending got %0d want 0",
                 nm[u], sq[u].size() + dq[u].size());
      end
    end
    n_cmp++;
    if (z_off != 0) begin
      n_bad++;
      $display("FAIL amp0 non-mid cycles got %0d want 0", z_off);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(60000 * 20);
    n_bad++;
    $display("FAIL watchdog cycles got %0d want < 60000", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
